// File: rtl/line_buffer_ctrl.sv
// Line-buffer write/read address controller with ping-pong banks and frame/line tracking.
// Optional macro LB_CTRL_LINE_ERR_EN enables the sticky line-overflow flag on o_err.
module line_buffer_ctrl #(
  parameter int X_CNT_WIDTH = 13,
  parameter int Y_CNT_WIDTH = 12,
  parameter int LINE_MAX    = 1920
) (
  input  logic                   i_pclk,
  input  logic                   i_srst,
  input  logic                   i_vsync,
  input  logic                   i_hsync,
  input  logic                   i_de,
  input  logic                   i_valid,
  output logic                   o_wr_en,
  output logic [X_CNT_WIDTH:0]   o_wr_addr,
  output logic [X_CNT_WIDTH:0]   o_rd_addr,
  output logic [X_CNT_WIDTH-1:0] o_x,
  output logic [Y_CNT_WIDTH-1:0] o_y,
  output logic                   o_line_valid,
  output logic                   o_frame_start,
  output logic                   o_line_end,
  output logic [X_CNT_WIDTH:0]   o_line_len,
  output logic                   o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LINE  = 2'd2,
    BLANK = 2'd3
  } state_t;

  localparam logic [X_CNT_WIDTH:0] LMAX = (X_CNT_WIDTH+1)'(LINE_MAX);

  state_t                 state_q, state_d;
  logic                   vs_d, hs_d, de_d;
  logic                   bank;
  // One extra bit so a line of exactly 2^X_CNT_WIDTH pixels can be counted.
  logic [X_CNT_WIDTH:0]   x;
  logic [Y_CNT_WIDTH-1:0] y;

  logic vs_rise, de_fall, active, wr;
  logic unused_hs;

  assign vs_rise   = i_vsync & ~vs_d;
  assign de_fall   = ~i_de & de_d;
  assign active    = (state_q != IDLE);
  assign wr        = active & i_valid & (x < LMAX);
  assign unused_hs = hs_d;

  assign o_x = x[X_CNT_WIDTH-1:0];
  assign o_y = y;

  always_ff @(posedge i_pclk) begin
    if (i_srst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (vs_rise) state_d = SYNC;
      SYNC:  if (vs_rise) state_d = SYNC;
             else if (i_de) state_d = LINE;
      LINE:  if (vs_rise) state_d = SYNC;
             else if (de_fall) state_d = BLANK;
      BLANK: if (vs_rise) state_d = SYNC;
             else if (i_de) state_d = LINE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_srst) begin
      vs_d          <= 1'b0;
      hs_d          <= 1'b0;
      de_d          <= 1'b0;
      bank          <= 1'b0;
      x             <= '0;
      y             <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_rd_addr     <= {1'b1, {X_CNT_WIDTH{1'b0}}};
      o_line_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_line_end    <= 1'b0;
      o_line_len    <= '0;
    end else begin
      vs_d          <= i_vsync;
      hs_d          <= i_hsync;
      de_d          <= i_de;
      o_frame_start <= 1'b0;
      o_line_end    <= 1'b0;
      o_wr_en       <= wr;
      o_wr_addr     <= {bank, x[X_CNT_WIDTH-1:0]};
      o_rd_addr     <= {~bank, x[X_CNT_WIDTH-1:0]};
      // vs_rise outranks a coincident de_fall: the partial line is discarded.
      if (vs_rise) begin
        x             <= '0;
        y             <= '0;
        bank          <= 1'b0;
        o_line_valid  <= 1'b0;
        o_frame_start <= 1'b1;
      end else if (active && de_fall) begin
        o_line_len   <= x;
        x            <= '0;
        bank         <= ~bank;
        if (y != '1) y <= y + 1'b1;
        o_line_valid <= 1'b1;
        o_line_end   <= 1'b1;
      end else if (wr) begin
        x <= x + 1'b1;
      end
    end
  end

`ifdef LB_CTRL_LINE_ERR_EN
  always_ff @(posedge i_pclk) begin
    if (i_srst)                             o_err <= 1'b0;
    else if (vs_rise)                       o_err <= 1'b0;
    else if (active && i_valid && x == LMAX) o_err <= 1'b1;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl (default and LINE_MAX=4 instances).
module tb_line_buffer_ctrl;

  logic clk = 1'b0;
  logic srst, vsync, hsync, de, valid;

  logic        wr_en, line_valid, frame_start, line_end, err;
  logic [13:0] wr_addr, rd_addr, line_len;
  logic [12:0] x;
  logic [11:0] y;

  logic        wr_en4, line_valid4, frame_start4, line_end4, err4;
  logic [13:0] wr_addr4, rd_addr4, line_len4;
  logic [12:0] x4;
  logic [11:0] y4;

  int checks   = 0;
  int failures = 0;
  logic exp_err;

  always #5 clk = ~clk;

  line_buffer_ctrl dut (
    .i_pclk(clk), .i_srst(srst), .i_vsync(vsync), .i_hsync(hsync), .i_de(de), .i_valid(valid),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_rd_addr(rd_addr), .o_x(x), .o_y(y),
    .o_line_valid(line_valid), .o_frame_start(frame_start), .o_line_end(line_end),
    .o_line_len(line_len), .o_err(err)
  );

  line_buffer_ctrl #(.LINE_MAX(4)) dut4 (
    .i_pclk(clk), .i_srst(srst), .i_vsync(vsync), .i_hsync(hsync), .i_de(de), .i_valid(valid),
    .o_wr_en(wr_en4), .o_wr_addr(wr_addr4), .o_rd_addr(rd_addr4), .o_x(x4), .o_y(y4),
    .o_line_valid(line_valid4), .o_frame_start(frame_start4), .o_line_end(line_end4),
    .o_line_len(line_len4), .o_err(err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic v, input logic d, input logic val);
    vsync = v;
    de    = d;
    valid = val;
    hsync = ~d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'h2000);
    chk({tag, "_line_valid"}, 32'(line_valid), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_line_end"}, 32'(line_end), 0);
    chk({tag, "_line_len"}, 32'(line_len), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_err4"}, 32'(err4), 0);
  endtask

  initial begin
`ifdef LB_CTRL_LINE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    srst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; valid = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_reset_vals("rst");
    srst = 1'b0;

    // Line without prior vsync is ignored
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1);
      chk("idle_wr_en", 32'(wr_en), 0);
    end
    cyc(0, 0, 0);
    chk("idle_line_end", 32'(line_end), 0);

    cyc(1, 0, 0);
    chk("vs_frame_start", 32'(frame_start), 1);
    cyc(0, 0, 0);
    chk("vs_frame_start_clr", 32'(frame_start), 0);

    // Three lines of four pixels, ping-pong banks
    for (int ln = 0; ln < 3; ln++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(0, 1, 1);
        chk("line_wr_en", 32'(wr_en), 1);
        chk("line_wr_addr", 32'(wr_addr), ((ln % 2) == 1 ? 32'h2000 : 32'h0) + 32'(k));
        chk("line_rd_addr", 32'(rd_addr), ((ln % 2) == 1 ? 32'h0 : 32'h2000) + 32'(k));
        chk("line_y", 32'(y), 32'(ln));
        chk("line_valid_pre", 32'(line_valid), (ln == 0) ? 0 : 1);
      end
      cyc(0, 0, 0);
      chk("de_fall_line_end", 32'(line_end), 1);
      chk("de_fall_line_len", 32'(line_len), 4);
      chk("de_fall_y", 32'(y), 32'(ln + 1));
      chk("de_fall_line_valid", 32'(line_valid), 1);
      chk("de_fall_wr_en", 32'(wr_en), 0);
      cyc(0, 0, 0);
      chk("blank_line_end", 32'(line_end), 0);
    end

    // Overflow on the LINE_MAX=4 instance
    cyc(1, 0, 0);
    chk("ovf_frame_start", 32'(frame_start4), 1);
    cyc(0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, 1);
      chk("ovf_wr_en4", 32'(wr_en4), (k < 4) ? 1 : 0);
      chk("ovf_wr_en", 32'(wr_en), 1);
      chk("ovf_err4", 32'(err4), (k >= 4) ? 32'(exp_err) : 0);
    end
    cyc(0, 0, 0);
    chk("ovf_line_len4", 32'(line_len4), 4);
    chk("ovf_line_len", 32'(line_len), 6);
    chk("ovf_err4_hold", 32'(err4), 32'(exp_err));
    chk("ovf_err_default", 32'(err), 0);
    cyc(0, 0, 0);

    // vs_rise coincident with de_fall (bank currently 1)
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    chk("pre_coinc_bank", 32'(wr_addr), 32'h2001);
    cyc(1, 0, 0);
    chk("coinc_frame_start", 32'(frame_start), 1);
    chk("coinc_line_end", 32'(line_end), 0);
    chk("coinc_line_valid", 32'(line_valid), 0);
    chk("coinc_line_len", 32'(line_len), 6);
    chk("coinc_err4_clr", 32'(err4), 0);
    cyc(0, 0, 0);
    chk("coinc_wr_addr", 32'(wr_addr), 0);
    chk("coinc_rd_addr", 32'(rd_addr), 32'h2000);
    chk("coinc_y", 32'(y), 0);

    // Reset mid-line at x=3
    for (int k = 0; k < 3; k++) cyc(0, 1, 1);
    chk("mid_x", 32'(x), 3);
    srst = 1'b1;
    cyc(0, 1, 1);
    chk_reset_vals("midrst");
    srst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 1);
      chk("postrst_wr_en", 32'(wr_en), 0);
    end
    cyc(0, 0, 0);
    chk("postrst_line_end", 32'(line_end), 0);
    chk("postrst_line_len", 32'(line_len), 0);
    cyc(1, 0, 0);
    chk("postrst_frame_start", 32'(frame_start), 1);
    cyc(0, 1, 1);
    chk("postrst_wr_en_ok", 32'(wr_en), 1);
    chk("postrst_wr_addr", 32'(wr_addr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
